// File: rtl/data_memory_responder.sv
// ----------------------------------------------------------------------------
// data_memory_responder
//
// Responder end of the CPU data-memory port. A load or store request is
// captured in IDLE, the pipeline is stalled through BUSYWAIT for a
// programmable latency, the access commits on the last BUSY edge, and one
// ACK cycle with BUSYWAIT low lets the cpu advance.
//
// Parameters
//   ADDR_WIDTH : word-index bits, array depth is 2**ADDR_WIDTH 32-bit words
//   LATENCY    : cycles spent in BUSY before commit (1..255)
//
// Ports
//   CLK        : clock, rising edge
//   RESET      : asynchronous active-low reset
//   READ[3:0]  : [3] read enable, [2:0] load funct3
//   WRITE[2:0] : [2] write enable, [1:0] store funct3[1:0]
//   ADDRESS    : byte address (upper bits alias)
//   WRITE_DATA : store data, right-aligned
//   READ_DATA  : registered, extended load result
//   BUSYWAIT   : stall request to the cpu
// ----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);

    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Select a byte or halfword from the word and extend it per load funct3.
    // Unlisted codes (011, 110, 111) return the whole word.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [2:0]  f3,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Merge right-aligned store data into the old word; code 11 acts as SW.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [1:0]  f3,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = word;
        case (f3)
            2'b00: r[{lane, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = data[15:0];
                end else begin
                    r[15:0] = data[15:0];
                end
            end
            default: r = data;
        endcase
        return r;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [7:0]              cnt_r;
    logic                    rd_en_r;
    logic [2:0]              rd_f3_r;
    logic                    wr_en_r;
    logic [1:0]              wr_f3_r;
    logic [ADDR_WIDTH+1:0]   addr_r;
    logic [31:0]             wdata_r;
    logic [31:0]             read_data_r;
    logic [31:0]             mem_r [DEPTH];
    logic                    req_s;
    logic                    capture_s;
    logic                    commit_s;
    logic                    busy_s;
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic [1:0]              lane_s;
    logic                    unused_addr_s;

    assign req_s     = READ[3] | WRITE[2];
    assign capture_s = (state_r == ST_IDLE) && req_s;
    assign commit_s  = (state_r == ST_BUSY) && (cnt_r == 8'd0);
    assign idx_s     = addr_r[ADDR_WIDTH+1:2];
    assign lane_s    = addr_r[1:0];

    // Upper address bits only alias; they are deliberately discarded.
    assign unused_addr_s = ^ADDRESS[31:ADDR_WIDTH+2];

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and stall logic; IDLE stalls combinationally on a new request.
    always_comb begin
        state_nxt_s = state_r;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = req_s & RESET;
                if (req_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                busy_s = 1'b1;
                if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_ACK: begin
                busy_s      = 1'b0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                busy_s      = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign BUSYWAIT = busy_s;

    // Latency counter: loaded on capture, counts down while BUSY.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_r <= 8'd0;
        end else if (capture_s) begin
            cnt_r <= LAT_M1;
        end else if ((state_r == ST_BUSY) && (cnt_r != 8'd0)) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request capture; BUSY ignores the live inputs and uses only these.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_en_r <= 1'b0;
            rd_f3_r <= 3'd0;
            wr_en_r <= 1'b0;
            wr_f3_r <= 2'd0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
        end else if (capture_s) begin
            rd_en_r <= READ[3];
            rd_f3_r <= READ[2:0];
            wr_en_r <= WRITE[2];
            wr_f3_r <= WRITE[1:0];
            addr_r  <= ADDRESS[ADDR_WIDTH+1:0];
            wdata_r <= WRITE_DATA;
        end else begin
            rd_en_r <= rd_en_r;
            rd_f3_r <= rd_f3_r;
            wr_en_r <= wr_en_r;
            wr_f3_r <= wr_f3_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Storage array; not reset. Reset forces IDLE, so an aborted store never commits.
    always_ff @(posedge CLK) begin
        if (commit_s && wr_en_r) begin
            mem_r[idx_s] <= store_merge(mem_r[idx_s], wdata_r, wr_f3_r, lane_s);
        end
    end

    // Load result register; a request that is both read and write acts as a store only.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            read_data_r <= 32'd0;
        end else if (commit_s && rd_en_r && !wr_en_r) begin
            read_data_r <= load_extend(mem_r[idx_s], rd_f3_r, lane_s);
        end else begin
            read_data_r <= read_data_r;
        end
    end

    assign READ_DATA = read_data_r;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the CPU data-memory interface: accepts the MEM-stage read/write strobes, address and store data, and stalls the pipeline through BUSYWAIT for a programmable access latency.
- Performs RV32IM byte, halfword and word loads and stores against an internal word-organised array.
- Returns sign- or zero-extended load data.
- Sits between the cpu data port (DATA_MEM_* signals) and the top-level testbench/SoC wrapper.

Parameters:
- ADDR_WIDTH, 8, word-index bits; array depth is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 4, cycles spent in BUSY before the access commits; legal range 1..255.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  4  [3] = read enable; [2:0] = load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- WRITE  input  3  [2] = write enable; [1:0] = store funct3[1:0] (00 SB, 01 SH, 10 SW).
- ADDRESS  input  32  byte address.
- WRITE_DATA  input  32  store data; right-aligned byte/half in the low bits.
- READ_DATA  output  32  extended load result.
- BUSYWAIT  output  1  stall request to the cpu.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, counter=0, captured request cleared, READ_DATA=0.
  - Array contents are not modified.
  - Reset during BUSY aborts the access; a pending store is dropped.
- Request detection: req = READ[3] | WRITE[2].
- States: IDLE, BUSY, ACK.
- IDLE:
  - BUSYWAIT = req (combinational, so the cpu stalls in the same cycle).
  - On an edge with req=1: capture ADDRESS, WRITE_DATA, READ, WRITE; counter = LATENCY-1; go to BUSY.
  - If req=0, stay in IDLE.
- BUSY:
  - BUSYWAIT=1. Input changes are ignored; only the captured request is used.
  - On an edge with counter!=0: decrement counter.
  - On an edge with counter==0: commit the access and go to ACK.
- ACK:
  - BUSYWAIT=0 for exactly one cycle; the cpu advances on this edge.
  - Inputs in this cycle belong to the completed request and are ignored.
  - Next state is IDLE unconditionally.
- Latency:
  - BUSYWAIT is high for LATENCY+1 cycles per access, followed by one ACK cycle.
  - A back-to-back request is first seen in IDLE, one cycle after ACK.
- Word index = captured ADDRESS[ADDR_WIDTH+1:2]. Upper address bits are ignored, so out-of-range addresses alias/wrap.
- Byte lane = ADDRESS[1:0].
- Alignment:
  - Halfword accesses use ADDRESS[1] and ignore ADDRESS[0].
  - Word accesses ignore ADDRESS[1:0].
  - Misaligned accesses are aligned down; no fault is raised.
- Store commit:
  - SB writes WRITE_DATA[7:0] into the lane selected by ADDRESS[1:0].
  - SH writes WRITE_DATA[15:0] into the half selected by ADDRESS[1].
  - SW writes the full word.
  - Other bytes of the word are unchanged.
  - Store code 11 is treated as SW.
- Load commit:
  - Select the lane/half and extend it: LB/LH sign-extend, LBU/LHU zero-extend.
  - Load codes 011, 110 and 111 are treated as LW.
  - The result is registered into READ_DATA on the commit edge, so it is valid throughout ACK.
- Stores leave READ_DATA unchanged. READ_DATA holds its value until the next load commits.
- READ[3] and WRITE[2] both set at capture: the access is performed as a store only; READ_DATA is unchanged.
- A read commit and its write-back are never split: one access per BUSY episode.

Test Plan:
- Reset and idle:
  - Stimulus: assert RESET low mid-BUSY of an SW with 0xDEADBEEF to address 0x10, then release and LW 0x10.
  - Required: READ_DATA=0 and BUSYWAIT=0 immediately; the word at 0x10 is unchanged (prior value 0x00000000 returned).
- Latency:
  - Stimulus: LATENCY=4, LW request held.
  - Required: BUSYWAIT high exactly 5 cycles, low 1 cycle (ACK); READ_DATA valid in ACK.
  - Repeat with LATENCY=1: BUSYWAIT high exactly 2 cycles.
- Byte/half stores and loads:
  - Stimulus: SW 0x00000000 at 0x20; SB 0x80 at 0x21; SH 0xFFFE at 0x22.
  - Required: LW 0x20 → 0xFFFE8000; LB 0x21 → 0xFFFFFF80; LBU 0x21 → 0x00000080; LH 0x22 → 0xFFFFFFFE; LHU 0x22 → 0x0000FFFE.
- Misaligned/aliasing:
  - LW at 0x23 returns the word at 0x20.
  - With ADDR_WIDTH=8, SW 0x12345678 to 0x400 then LW 0x000 → 0x12345678.
- Capture and conflicts:
  - Change ADDRESS/WRITE_DATA during BUSY: the originally captured values are used.
  - READ[3]=WRITE[2]=1 with SW 0xA5A5A5A5 at 0x30: the store happens and READ_DATA keeps its prior value.
- Back-to-back:
  - Stimulus: SW then LW to the same address, presented on consecutive post-ACK cycles.
  - Required: the load returns the stored value; BUSYWAIT re-asserts in the cycle after ACK.
